// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: PC sequencer state encoding and the increment constant.
package nrisc_pkg;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      SOMA1  = 2'd1,
      SOMA2  = 2'd2,
      PARADO = 2'd3
   } estado_t;

   localparam logic [7:0] INCREMENTO = 8'd1;

endpackage

// File: rtl/controle_pc.sv
// nRISC program-counter sequencer: owns the PC and time-shares the external adder
// between PC+1 and the branch-target add, one accepted instruction at a time.
module controle_pc
   import nrisc_pkg::*;
#(
   parameter int                 LARGURA  = 8,
   parameter logic [LARGURA-1:0] PC_RESET = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               is_branch,
   input  logic               cond,
   input  logic               is_halt,
   input  logic [LARGURA-1:0] offset,
   input  logic               stall,
   output logic [LARGURA-1:0] soma_a,
   output logic [LARGURA-1:0] soma_b,
   input  logic [LARGURA-1:0] soma_r,
   output logic [LARGURA-1:0] pc,
   output logic               pc_pronto,
   output logic               desvio,
   output logic               parado,
   output estado_t            estado
);

   estado_t            estado_next;
   logic [LARGURA-1:0] pc1_reg;
   logic [LARGURA-1:0] offset_reg;
   logic               taken_reg;
   logic               accept;
   logic               pc_we;
   logic               pc1_we;
   logic               pronto_next;
   logic               desvio_next;

   // Handshake: an instruction is taken on the rising edge where req_valid & req_ready;
   // the requester keeps req_valid and its fields stable until that edge.
   assign req_ready = (estado == OCIOSO);
   assign parado    = (estado == PARADO);
   assign accept    = req_valid & req_ready;

   always_comb begin
      estado_next = estado;
      soma_a      = pc;
      soma_b      = '0;
      pc_we       = 1'b0;
      pc1_we      = 1'b0;
      pronto_next = 1'b0;
      desvio_next = 1'b0;
      case (estado)
         OCIOSO: begin
            if (accept) estado_next = is_halt ? PARADO : SOMA1;
         end
         SOMA1: begin
            soma_b = LARGURA'(INCREMENTO);
            if (!stall) begin
               if (taken_reg) begin
                  pc1_we      = 1'b1;
                  estado_next = SOMA2;
               end else begin
                  pc_we       = 1'b1;
                  pronto_next = 1'b1;
                  estado_next = OCIOSO;
               end
            end
         end
         SOMA2: begin
            // Second pass reuses the adder: (PC+1) + offset.
            soma_a = pc1_reg;
            soma_b = offset_reg;
            if (!stall) begin
               pc_we       = 1'b1;
               pronto_next = 1'b1;
               desvio_next = 1'b1;
               estado_next = OCIOSO;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         pc         <= PC_RESET;
         pc1_reg    <= '0;
         offset_reg <= '0;
         taken_reg  <= 1'b0;
         pc_pronto  <= 1'b0;
         desvio     <= 1'b0;
      end else begin
         estado    <= estado_next;
         pc_pronto <= pronto_next;
         desvio    <= desvio_next;
         if (pc_we)  pc      <= soma_r;
         if (pc1_we) pc1_reg <= soma_r;
         if (accept) begin
            taken_reg  <= is_branch & cond;
            offset_reg <= offset;
         end
      end
   end

endmodule
